// File: rtl/c4_turn_ctrl_if.sv
// Connect Four turn-controller bus: raw buttons and win result in,
// move command plus status out. The slave modport is the controller side.
interface c4_turn_ctrl_if #(
    parameter int NUM_COLS = 7
);
    logic                btn_left;
    logic                btn_right;
    logic                btn_drop;
    logic [1:0]          win_in;
    logic [2:0]          column;
    logic                player;
    logic                confirm_move;
    logic [NUM_COLS-1:0] col_full;
    logic [5:0]          move_count;
    logic                illegal_move;
    logic                busy;
    logic                game_over;
    logic                draw;

    modport master (
        output btn_left, btn_right, btn_drop, win_in,
        input  column, player, confirm_move, col_full, move_count,
               illegal_move, busy, game_over, draw
    );

    modport slave (
        input  btn_left, btn_right, btn_drop, win_in,
        output column, player, confirm_move, col_full, move_count,
               illegal_move, busy, game_over, draw
    );
endinterface

// File: rtl/c4_turn_ctrl.sv
// Connect Four turn controller: debounced-edge buttons to legal move strobes,
// column heights, player alternation, win/draw detection. Option: C4_SKIP_FULL_EN.
module c4_turn_ctrl #(
    parameter int NUM_COLS      = 7,
    parameter int NUM_ROWS      = 6,
    parameter int START_COL     = 3,
    parameter int FIRST_PLAYER  = 1,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    c4_turn_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_SELECT,
        S_ISSUE,
        S_SETTLE,
        S_CHECK,
        S_OVER
    } state_e;

    localparam logic [2:0] LAST_COL    = 3'(NUM_COLS - 1);
    localparam logic [2:0] FULL_H      = 3'(NUM_ROWS);
    localparam logic [5:0] MAX_MOVES   = 6'(NUM_COLS * NUM_ROWS);
    localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [2:0]          column_q, column_d;
    logic                player_q, player_d;
    logic                confirm_q, confirm_d;
    logic                illegal_q, illegal_d;
    logic                draw_q, draw_d;
    logic [5:0]          move_count_q, move_count_d;
    logic [2:0]          height_q [NUM_COLS];
    logic                height_inc;
    logic [NUM_COLS-1:0] col_full;
    logic [2:0]          sync1_q, sync2_q, prev_q;
    logic [2:0]          ev;

    // Only bit0 of the win result carries meaning here.
    logic unused_win;
    assign unused_win = bus.win_in[1];

    function automatic logic [2:0] step(input logic [2:0] c, input logic right);
        if (right) return (c == LAST_COL) ? 3'd0 : c + 3'd1;
        else       return (c == 3'd0) ? LAST_COL : c - 3'd1;
    endfunction

`ifdef C4_SKIP_FULL_EN
    // Nearest non-full column in the given direction; stays put if none.
    function automatic logic [2:0] seek(input logic [2:0] c, input logic right,
                                        input logic [NUM_COLS-1:0] full);
        logic [2:0] cand;
        logic       found;
        logic [2:0] res;
        cand  = c;
        found = 1'b0;
        res   = c;
        for (int i = 1; i < NUM_COLS; i++) begin
            cand = step(cand, right);
            if (!found && !full[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction
`endif

    // Bit order {drop, right, left}; 2-FF synchronizer then rising-edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage sample the previous stage's old value.
            sync1_q <= {bus.btn_drop, bus.btn_right, bus.btn_left};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end
    assign ev = sync2_q & ~prev_q;

    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) col_full[c] = (height_q[c] == FULL_H);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        column_d     = column_q;
        player_d     = player_q;
        move_count_d = move_count_q;
        draw_d       = draw_q;
        illegal_d    = 1'b0;
        height_inc   = 1'b0;
        unique case (state_q)
            S_SELECT: begin
                if (ev[2]) begin
                    if (col_full[column_q]) begin
                        illegal_d = 1'b1;
                    end else begin
                        height_inc   = 1'b1;
                        move_count_d = move_count_q + 6'd1;
                        cnt_d        = '0;
                        state_d      = S_ISSUE;
                    end
                end else if (ev[0] ^ ev[1]) begin
`ifdef C4_SKIP_FULL_EN
                    column_d = seek(column_q, ev[1], col_full);
`else
                    column_d = step(column_q, ev[1]);
`endif
                end
            end
            S_ISSUE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (bus.win_in[0]) begin
                    state_d = S_OVER;
                end else if (move_count_q == MAX_MOVES) begin
                    state_d = S_OVER;
                    draw_d  = 1'b1;
                end else begin
                    player_d = ~player_q;
                    state_d  = S_SELECT;
`ifdef C4_SKIP_FULL_EN
                    if (col_full[column_q]) column_d = seek(column_q, 1'b1, col_full);
`endif
                end
            end
            S_OVER:  ;
            default: state_d = S_SELECT;
        endcase
        // Registered strobe: high exactly while the FSM sits in ISSUE.
        confirm_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_SELECT;
            cnt_q        <= '0;
            column_q     <= 3'(START_COL);
            player_q     <= 1'(FIRST_PLAYER);
            confirm_q    <= 1'b0;
            illegal_q    <= 1'b0;
            draw_q       <= 1'b0;
            move_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            column_q     <= column_d;
            player_q     <= player_d;
            confirm_q    <= confirm_d;
            illegal_q    <= illegal_d;
            draw_q       <= draw_d;
            move_count_q <= move_count_d;
        end
    end

    // NOTE: heights are architectural board state and must clear with the game logic, so this array is reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_COLS; c++) height_q[c] <= '0;
        end else if (height_inc) begin
            height_q[column_q] <= height_q[column_q] + 3'd1;
        end
    end

    assign bus.column       = column_q;
    assign bus.player       = player_q;
    assign bus.confirm_move = confirm_q;
    assign bus.col_full     = col_full;
    assign bus.move_count   = move_count_q;
    assign bus.illegal_move = illegal_q;
    assign bus.busy         = (state_q == S_ISSUE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign bus.game_over    = (state_q == S_OVER);
    assign bus.draw         = draw_q;
endmodule

// File: tb/tb_c4_turn_ctrl.sv
// Self-checking bench for c4_turn_ctrl (default build, C4_SKIP_FULL_EN undefined):
// cursor vector table plus directed drop, fill, win, draw and mid-move reset sequences.
module tb_c4_turn_ctrl;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    c4_turn_ctrl_if #(.NUM_COLS(7)) bus ();

    c4_turn_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       l;
        logic       r;
        logic [2:0] exp_col;
    } cur_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_drop  = 1'b0;
        bus.win_in    = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Press buttons for 3 cycles, then observe a fixed 40-cycle window.
    task automatic press(input logic l, input logic r, input logic d,
                         output int conf_n, output int busy_n, output int ill_n,
                         output logic [2:0] conf_col, output logic conf_pl,
                         output logic col_moved);
        logic       seen;
        logic [2:0] prev_col;
        logic       prev_pl;
        conf_n    = 0;
        busy_n    = 0;
        ill_n     = 0;
        conf_col  = 3'd0;
        conf_pl   = 1'b0;
        col_moved = 1'b0;
        seen      = 1'b0;
        @(negedge clk);
        prev_col      = bus.column;
        prev_pl       = bus.player;
        bus.btn_left  = l;
        bus.btn_right = r;
        bus.btn_drop  = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) begin
                bus.btn_left  = 1'b0;
                bus.btn_right = 1'b0;
                bus.btn_drop  = 1'b0;
            end
            if (bus.confirm_move) begin
                if (!seen) begin
                    conf_col = bus.column;
                    conf_pl  = bus.player;
                    seen     = 1'b1;
                    if (prev_col != bus.column || prev_pl != bus.player) col_moved = 1'b1;
                end
                conf_n++;
            end
            if (bus.busy) begin
                busy_n++;
                if (seen && (bus.column != conf_col || bus.player != conf_pl)) col_moved = 1'b1;
            end
            if (bus.illegal_move) ill_n++;
            prev_col = bus.column;
            prev_pl  = bus.player;
        end
    endtask

    initial begin
        cur_vec_t   tbl [7];
        int         cn, bn, il;
        logic [2:0] cc;
        logic       cp, mv;
        int         bad;

        n_tests = 0;
        n_fail  = 0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_drop  = 1'b0;
        bus.win_in    = 2'b00;

        // Cursor walk starting from column 3 (after one move there, still column 3).
        tbl[0] = '{l: 1'b0, r: 1'b1, exp_col: 3'd4};
        tbl[1] = '{l: 1'b0, r: 1'b1, exp_col: 3'd5};
        tbl[2] = '{l: 1'b0, r: 1'b1, exp_col: 3'd6};
        tbl[3] = '{l: 1'b0, r: 1'b1, exp_col: 3'd0};
        tbl[4] = '{l: 1'b1, r: 1'b0, exp_col: 3'd6};
        tbl[5] = '{l: 1'b1, r: 1'b1, exp_col: 3'd6};
        tbl[6] = '{l: 1'b0, r: 1'b1, exp_col: 3'd0};

        // Asynchronous reset, checked before the first clock edge.
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_async_column", 32'(bus.column), 32'd3);
        check("rst_async_confirm", 32'(bus.confirm_move), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_column", 32'(bus.column), 32'd3);
        check("rst_player", 32'(bus.player), 32'd1);
        check("rst_confirm", 32'(bus.confirm_move), 32'd0);
        check("rst_col_full", 32'(bus.col_full), 32'd0);
        check("rst_move_count", 32'(bus.move_count), 32'd0);
        check("rst_game_over", 32'(bus.game_over), 32'd0);
        check("rst_draw", 32'(bus.draw), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_illegal", 32'(bus.illegal_move), 32'd0);

        // First move at column 3.
        press(1'b0, 1'b0, 1'b1, cn, bn, il, cc, cp, mv);
        check("drop1_confirm_cycles", 32'(cn), 32'd2);
        check("drop1_busy_cycles", 32'(bn), 32'd5);
        check("drop1_column", 32'(cc), 32'd3);
        check("drop1_player", 32'(cp), 32'd1);
        check("drop1_stable", 32'(mv), 32'd0);
        check("drop1_player_after", 32'(bus.player), 32'd0);
        check("drop1_move_count", 32'(bus.move_count), 32'd1);
        check("drop1_busy_after", 32'(bus.busy), 32'd0);

        // Cursor moves and wrap-around from the table.
        for (int i = 0; i < 7; i++) begin
            press(tbl[i].l, tbl[i].r, 1'b0, cn, bn, il, cc, cp, mv);
            check($sformatf("cursor_%0d_column", i), 32'(bus.column), 32'(tbl[i].exp_col));
            check($sformatf("cursor_%0d_no_confirm", i), 32'(cn), 32'd0);
        end
        check("cursor_move_count", 32'(bus.move_count), 32'd1);

        // Six drops fill column 0, the seventh is rejected.
        for (int k = 0; k < 6; k++) begin
            if (k == 5) check("fill_col_full_before_6th", 32'(bus.col_full), 32'd0);
            press(1'b0, 1'b0, 1'b1, cn, bn, il, cc, cp, mv);
            check($sformatf("fill_%0d_confirm", k), 32'(cn), 32'd2);
        end
        check("fill_col_full_after_6th", 32'(bus.col_full), 32'h01);
        check("fill_move_count", 32'(bus.move_count), 32'd7);
        check("fill_player", 32'(bus.player), 32'd0);
        press(1'b0, 1'b0, 1'b1, cn, bn, il, cc, cp, mv);
        check("full_illegal_cycles", 32'(il), 32'd1);
        check("full_no_confirm", 32'(cn), 32'd0);
        check("full_move_count", 32'(bus.move_count), 32'd7);

        // Drop together with right: move goes to the old column.
        press(1'b0, 1'b1, 1'b0, cn, bn, il, cc, cp, mv);
        press(1'b0, 1'b1, 1'b0, cn, bn, il, cc, cp, mv);
        check("nav_column", 32'(bus.column), 32'd2);
        press(1'b0, 1'b1, 1'b1, cn, bn, il, cc, cp, mv);
        check("drop_right_confirm", 32'(cn), 32'd2);
        check("drop_right_column", 32'(cc), 32'd2);
        check("drop_right_player", 32'(cp), 32'd0);
        check("drop_right_column_after", 32'(bus.column), 32'd2);
        check("drop_right_player_after", 32'(bus.player), 32'd1);

        // Win: the mover stays as player, later input is ignored.
        bus.win_in = 2'b01;
        press(1'b0, 1'b0, 1'b1, cn, bn, il, cc, cp, mv);
        bus.win_in = 2'b00;
        check("win_confirm", 32'(cn), 32'd2);
        check("win_game_over", 32'(bus.game_over), 32'd1);
        check("win_draw", 32'(bus.draw), 32'd0);
        check("win_player", 32'(bus.player), 32'd1);
        check("win_move_count", 32'(bus.move_count), 32'd9);
        press(1'b0, 1'b0, 1'b1, cn, bn, il, cc, cp, mv);
        check("over_no_confirm", 32'(cn), 32'd0);
        check("over_move_count", 32'(bus.move_count), 32'd9);
        press(1'b0, 1'b1, 1'b0, cn, bn, il, cc, cp, mv);
        check("over_column", 32'(bus.column), 32'd2);
        check("over_game_over", 32'(bus.game_over), 32'd1);

        // Draw: fill the whole board with no win.
        do_reset();
        bad = 0;
        for (int c = 0; c < 7; c++) begin
            for (int k = 0; k < 6; k++) begin
                if (c == 6 && k == 5) begin
                    check("draw_not_over_at_41", 32'(bus.game_over), 32'd0);
                    check("draw_count_41", 32'(bus.move_count), 32'd41);
                end
                press(1'b0, 1'b0, 1'b1, cn, bn, il, cc, cp, mv);
                if (cn != 2) bad++;
            end
            if (c != 6) press(1'b0, 1'b1, 1'b0, cn, bn, il, cc, cp, mv);
        end
        check("draw_all_moves_confirmed", 32'(bad), 32'd0);
        check("draw_move_count", 32'(bus.move_count), 32'd42);
        check("draw_col_full", 32'(bus.col_full), 32'h7f);
        check("draw_game_over", 32'(bus.game_over), 32'd1);
        check("draw_draw", 32'(bus.draw), 32'd1);
        check("draw_player", 32'(bus.player), 32'd0);

        // Reset in the middle of ISSUE.
        do_reset();
        bus.btn_drop = 1'b1;
        bad = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.confirm_move) begin
                bad = 0;
                break;
            end
        end
        check("midreset_issue_reached", 32'(bad), 32'd0);
        #1 reset = 1'b1;
        #1;
        check("midreset_confirm", 32'(bus.confirm_move), 32'd0);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_move_count", 32'(bus.move_count), 32'd0);
        check("midreset_column", 32'(bus.column), 32'd3);
        check("midreset_player", 32'(bus.player), 32'd1);
        check("midreset_col_full", 32'(bus.col_full), 32'd0);
        bus.btn_drop = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_after_confirm", 32'(bus.confirm_move), 32'd0);
        check("midreset_after_game_over", 32'(bus.game_over), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/c4_turn_ctrl.md
Name: c4_turn_ctrl

Overview:
- Upstream stage of the Connect Four game-logic block.
- Converts raw left/right/drop buttons into clean, legal move commands: one column, one player and one confirm pulse per move.
- Tracks column fill heights and alternates players.
- Samples the game-logic win result after each move to declare game over or a draw.

Parameters:
- NUM_COLS, 7, board columns; column width is 3 bits.
- NUM_ROWS, 6, board rows; a column is full at height NUM_ROWS.
- START_COL, 3, cursor column after reset.
- FIRST_PLAYER, 1, player value after reset. 1 maps to token 01, 0 maps to token 10.
- PULSE_CYCLES, 2, cycles confirm_move is held high.
- SETTLE_CYCLES, 2, cycles waited after the confirm pulse falls before win_in is sampled.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high; shared with the game-logic block
- btn_left  in  1  raw async button, move cursor left
- btn_right  in  1  raw async button, move cursor right
- btn_drop  in  1  raw async button, drop token in cursor column
- win_in  in  2  win result from game logic; bit0=1 means the last mover won
- column  out  3  cursor / move column, registered
- player  out  1  current mover, registered
- confirm_move  out  1  move strobe to game logic, registered
- col_full  out  NUM_COLS  bit c=1 when column c holds NUM_ROWS tokens
- move_count  out  6  tokens placed since reset
- illegal_move  out  1  1-cycle pulse: drop requested on a full column
- busy  out  1  high in ISSUE, SETTLE and CHECK
- game_over  out  1  sticky; high in OVER
- draw  out  1  sticky; board filled with no win

Behaviour:
- Reset values (async, immediate):
  - column=START_COL, player=FIRST_PLAYER.
  - confirm_move, illegal_move, busy, game_over, draw = 0.
  - move_count=0, all heights=0, col_full=0, state=SELECT.
- Input conditioning:
  - Each button passes through a 2-FF synchronizer, then rising-edge detect.
  - A clean edge yields a 1-cycle internal event on the 3rd clk edge after the button rises.
  - Level holds generate no further events.
- States: SELECT, ISSUE, SETTLE, CHECK, OVER. Events are acted on only in SELECT; in any other state they are discarded, not queued.
- SELECT, event priority:
  - Drop beats left/right.
  - Left and right together are ignored.
- SELECT, drop:
  - If col_full[column]=0: increment that column's height and move_count; go to ISSUE next cycle.
  - If col_full[column]=1: pulse illegal_move for 1 cycle; stay in SELECT.
- SELECT, cursor moves (left/right alone):
  - Left: column-1; from 0 it wraps to NUM_COLS-1.
  - Right: column+1; from NUM_COLS-1 it wraps to 0.
- ISSUE:
  - confirm_move=1 for exactly PULSE_CYCLES cycles, then SETTLE.
  - confirm_move rises only from a registered 0, with no glitches.
- SETTLE: confirm_move=0 for SETTLE_CYCLES cycles, then CHECK.
- Output stability: column and player are stable from the cycle before confirm_move rises through the end of CHECK.
- CHECK (1 cycle), priority order:
  - win_in[0]=1: go to OVER, game_over=1, player unchanged (identifies the winner).
  - Otherwise, move_count==NUM_COLS*NUM_ROWS: go to OVER, game_over=1, draw=1.
  - Otherwise: toggle player, go to SELECT.
- OVER: all buttons ignored; only reset exits.
- Reset mid-operation:
  - Reset during ISSUE drops confirm_move to 0 asynchronously.
  - Heights return to 0 consistent with game-logic reset.
- Widths:
  - Heights are 3-bit saturating at NUM_ROWS.
  - move_count is 6-bit and never exceeds 42.

Optional Feature:
- Macro: C4_SKIP_FULL_EN.
- Defined:
  - Left/right move the cursor to the nearest non-full column in that direction, with wrap.
  - If all other columns are full, the cursor stays put.
  - After CHECK, if the cursor column is full, the cursor auto-advances right to the next non-full column.
- Undefined: cursor steps one column regardless of fill; full columns are rejected only via illegal_move.

Test Plan:
- Reset asserted then released → column=3, player=1, confirm_move=0, col_full=0, move_count=0, game_over=0.
- Drop press at column 3 → confirm_move high exactly 2 cycles with column=3, player=1; after CHECK player=0, move_count=1; busy low again.
- Six drops in column 0, then a seventh → col_full[0]=1 after the sixth; seventh gives an illegal_move 1-cycle pulse and no confirm_move.
- Left at column 0 → 6; right at column 6 → 0; left+right together → unchanged; drop+right together → move issued at the old column.
- win_in=01 driven before CHECK → game_over=1, draw=0, player holds the mover; later drops produce no confirm_move.
- 42 legal moves with win_in=00 → draw=1, game_over=1. Separately, reset asserted mid-ISSUE → confirm_move falls same cycle and all state is at reset values.
